// File: rtl/json_int_array_encoder.sv
// Streams signed integers out as compact JSON array text, one ASCII byte per
// handshake, using a sequential shift-add-3 binary-to-BCD converter per element.
module json_int_array_encoder #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last
);

  // Decimal digit count of 2^(DATA_W-1); the magnitude of the most negative
  // value is the largest number the converter must represent.
  function automatic int num_digits(input int w);
    logic [64:0] v;
    int          n;
    v = 65'd1 << (w - 1);
    n = 0;
    for (int i = 0; i < 25; i++) begin
      if (v != 0) begin
        v = v / 65'd10;
        n++;
      end
    end
    return n;
  endfunction

  localparam int NDIG  = num_digits(DATA_W);
  localparam int BCD_W = 4 * NDIG;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = $clog2(NDIG);

  typedef enum logic [2:0] {IDLE, CONV, OPEN, SIGN, DIGITS, SEP} state_t;

  state_t             state;
  logic [BCD_W-1:0]   bcd;
  logic [DATA_W-1:0]  bin;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic               neg;
  logic               last_r;
  logic               first;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_step;
  logic [DATA_W-1:0]  bin_step;
  logic [IDX_W-1:0]   msd;
  logic [DATA_W-1:0]  mag;

  function automatic logic [7:0] digit_at(input logic [BCD_W-1:0] b,
                                          input logic [IDX_W-1:0] i);
    logic [BCD_W-1:0] s;
    s = b >> (4 * i);
    return 8'h30 + {4'h0, s[3:0]};
  endfunction

  // One double-dabble step: correct every digit >= 5, then shift the next
  // binary bit into the BCD register.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    bcd_adj = bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[BCD_W-2:0], bin[DATA_W-1]};
    bin_step = {bin[DATA_W-2:0], 1'b0};
  end

  // Most significant non-zero digit; stays 0 for the value zero so one '0' is sent.
  always_comb begin
    msd = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = IDX_W'(i);
    end
  end

  assign mag = in_data[DATA_W-1] ? (~in_data) + DATA_W'(1) : in_data;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      // NOTE: the digit buffer is reset explicitly so a restart never sees stale digits.
      bcd       <= '0;
      bin       <= '0;
      cnt       <= '0;
      idx       <= '0;
      neg       <= 1'b0;
      last_r    <= 1'b0;
      first     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            bin      <= mag;
            neg      <= in_data[DATA_W-1];
            last_r   <= in_last;
            bcd      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CONV;
          end else begin
            in_ready <= 1'b1;
          end
        end
        CONV: begin
          if (cnt != CNT_W'(DATA_W)) begin
            bcd <= bcd_step;
            bin <= bin_step;
            cnt <= cnt + CNT_W'(1);
          end else begin
            // Conversion finished; locate the leading digit and present the first byte.
            idx       <= msd;
            out_valid <= 1'b1;
            if (first) begin
              state    <= OPEN;
              out_data <= 8'h5B;
            end else if (neg) begin
              state    <= SIGN;
              out_data <= 8'h2D;
            end else begin
              state    <= DIGITS;
              out_data <= digit_at(bcd, msd);
            end
          end
        end
        OPEN: begin
          if (out_ready) begin
            if (neg) begin
              state    <= SIGN;
              out_data <= 8'h2D;
            end else begin
              state    <= DIGITS;
              out_data <= digit_at(bcd, idx);
            end
          end
        end
        SIGN: begin
          if (out_ready) begin
            state    <= DIGITS;
            out_data <= digit_at(bcd, idx);
          end
        end
        DIGITS: begin
          if (out_ready) begin
            if (idx == '0) begin
              state    <= SEP;
              out_data <= last_r ? 8'h5D : 8'h2C;
              out_last <= last_r;
            end else begin
              idx      <= idx - IDX_W'(1);
              out_data <= digit_at(bcd, idx - IDX_W'(1));
            end
          end
        end
        SEP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= 8'h00;
            first     <= last_r;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/json_int_array_encoder.md
JSON_INT_ARRAY_ENCODER -- requirements
Module: json_int_array_encoder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the signed input integer width; legal range 8..64.
REQ-002 SHALL have derived localparam NDIG, the decimal digit count of 2^(DATA_W-1) (10 for DATA_W=32), sizing the digit buffer.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  input element present.
REQ-006 SHALL have port in_ready  output  1  encoder can accept an element.
REQ-007 SHALL have port in_data  input  DATA_W  signed two's-complement element value.
REQ-008 SHALL have port in_last  input  1  element is the final one of the current array.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid ASCII byte.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the byte.
REQ-011 SHALL have port out_data  output  8  ASCII character of the JSON text.
REQ-012 SHALL have port out_last  output  1  asserted with the closing ']' byte only.

Function
REQ-013 SHALL serialise a sequence of elements into compact JSON array text, e.g. 5, -23, 0 (last) -> "[5,-23,0]", no whitespace.
REQ-014 SHALL use states IDLE, CONV, OPEN, SIGN, DIGITS, SEP; in_ready SHALL be 1 only in IDLE.
REQ-015 SHALL, on in_valid && in_ready in IDLE, capture in_data and in_last, latch the sign, compute the magnitude as unsigned DATA_W bits, and go to CONV.
REQ-016 SHALL, in CONV, run shift-add-3 binary-to-BCD conversion for exactly DATA_W cycles, then go to OPEN if the element is the first of an array, otherwise SIGN.
REQ-017 SHALL, in OPEN, emit '['; in SIGN, emit '-' only for negative values, skipping SIGN when non-negative.
REQ-018 SHALL, in DIGITS, emit digits most-significant first with leading zeros suppressed; value 0 SHALL emit a single '0'.
REQ-019 SHALL, in SEP, emit ',' when in_last was 0, or ']' with out_last=1 when in_last was 1, then return to IDLE.
REQ-020 SHALL, after ']', treat the next accepted element as the first of a new array.
REQ-021 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0; a byte SHALL advance only on out_valid && out_ready.
REQ-022 SHALL assert out_valid continuously from the first byte of an element through its separator, with no gap cycles when out_ready stays 1.
REQ-023 SHALL assert the first out_valid for an element exactly DATA_W+1 cycles after its accepting edge.
REQ-024 SHALL encode the most negative value -2^(DATA_W-1) correctly, e.g. DATA_W=8, -128 -> "-128".
REQ-025 SHALL ignore in_data, in_last and in_valid outside IDLE.
REQ-026 SHALL produce one element's bytes in 2+D cycles minimum (sign/open, D digits, separator), plus DATA_W conversion cycles.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge, enter IDLE and set in_ready=0, out_valid=0, out_data=8'h00, out_last=0, clear the BCD buffer, and set the first-element flag.
REQ-028 SHALL assert in_ready=1 in the first cycle after rst_n returns to 1.
REQ-029 SHALL discard any partially emitted array on reset mid-operation; the next accepted element SHALL begin with '['.

Verification
REQ-030 SHALL be verified for DATA_W=32 with values 7, -42, 1000 (last) and out_ready=1 -> bytes "[7,-42,1000]", with out_last only on ']'.
REQ-031 SHALL be verified for single element 0 (last) -> "[0]"; for -2147483648 (last) -> "[-2147483648]"; for 2147483647 (last) -> "[2147483647]".
REQ-032 SHALL be verified with out_ready toggling pseudo-randomly over "[123,-5]" -> identical byte sequence, out_data stable under stall, no dropped or duplicated bytes.
REQ-033 SHALL be verified with element accepted at cycle T -> first out_valid at cycle T+33; in_valid pulses during CONV/DIGITS ignored.
REQ-034 SHALL be verified with rst_n low for one cycle after "[12," has been emitted, then 9 (last) -> "[9]" with all outputs at reset values during reset.
REQ-035 SHALL be verified with two back-to-back arrays 1 (last), 2 (last) -> "[1]" then "[2]", each with its own out_last.
